// File: rtl/key_load_ctrl.sv
// Debounced load-strobe controller for three push-button keys (A, B, F).
// Define KEY_ORDER_LOCK_EN to enforce the A -> B -> F load order.
module key_load_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_a,
  input  logic       key_b,
  input  logic       key_f,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_f,
  output logic [2:0] held,
  output logic       order_err
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } key_st_e;

  logic [2:0] raw;
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;

  key_st_e    state_q [3];
  key_st_e    state_d [3];
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  logic [2:0] cand;
  logic [2:0] pass;
  logic [2:0] held_q, held_d;
  logic [2:0] ld_q, ld_d;
  logic       err_q, err_d;

  assign raw = {key_f, key_b, key_a};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cand    = '0;
    held_d  = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = DB_PRESS;
            cnt_d[i]   = '0;
          end
        end
        DB_PRESS: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = HELD;
            cand[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = DB_RELEASE;
            cnt_d[i]   = '0;
          end
        end
        DB_RELEASE: begin
          if (sync2_q[i]) begin
            state_d[i] = HELD;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
      held_d[i] = (state_d[i] == HELD) ||
                  (state_d[i] == DB_RELEASE);
    end
  end

`ifdef KEY_ORDER_LOCK_EN
  typedef enum logic [1:0] {
    WAIT_A,
    WAIT_B,
    WAIT_F
  } seq_e;

  seq_e seq_q, seq_d;

  // Candidates are judged against the current sequencer state;
  // an A load overrides any other next-state move.
  always_comb begin
    seq_d   = seq_q;
    pass[0] = cand[0];
    pass[1] = cand[1] && (seq_q == WAIT_B);
    pass[2] = cand[2] && (seq_q == WAIT_F);
    if (pass[2]) seq_d = WAIT_A;
    if (pass[1]) seq_d = WAIT_F;
    if (pass[0]) seq_d = WAIT_B;
    err_d = |(cand & ~pass);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) seq_q <= WAIT_A;
    else        seq_q <= seq_d;
  end
`else
  always_comb begin
    pass  = cand;
    err_d = 1'b0;
  end
`endif

  assign ld_d = pass;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      held_q  <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      held_q  <= held_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign ld_a      = ld_q[0];
  assign ld_b      = ld_q[1];
  assign ld_f      = ld_q[2];
  assign held      = held_q;
  assign order_err = err_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Scoreboard bench for key_load_ctrl with DEBOUNCE_CYCLES = 4.
// Expected strobe events are queued by stimulus and checked by a monitor.
module tb_key_load_ctrl;

  localparam int D = 4;
  localparam int LAT = D + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_a, key_b, key_f;
  logic       ld_a, ld_b, ld_f;
  logic [2:0] held;
  logic       order_err;

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } exp_t;

  exp_t exp_q [$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef KEY_ORDER_LOCK_EN
  localparam logic [3:0] F_EV = 4'b1000;
`else
  localparam logic [3:0] F_EV = 4'b0100;
`endif

  key_load_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_a    (key_a),
    .key_b    (key_b),
    .key_f    (key_f),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .ld_f     (ld_f),
    .held     (held),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe or error pulse must match the queue head.
  always @(negedge clk) begin
    logic [3:0] got;
    exp_t e;
    got = {order_err, ld_f, ld_b, ld_a};
    if (rst_n === 1'b1 && got != 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_event: got %b at cycle %0d",
                 got, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_value", {28'd0, got}, {28'd0, e.v});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    key_a = 1'b0;
    key_b = 1'b0;
    key_f = 1'b0;
    step(3);
    rst_n = 1'b1;
    chk("reset_outputs",
        {25'd0, order_err, ld_f, ld_b, ld_a, held}, 32'd0);
    step(2);

    // Clean press and release on A
    key_a = 1'b1;
    push(cyc + LAT, 4'b0001);
    step(20);
    chk("a_held_press", {31'd0, held[0]}, 32'd1);
    key_a = 1'b0;
    step(6);
    chk("a_held_late", {31'd0, held[0]}, 32'd1);
    step(1);
    chk("a_held_drop", {31'd0, held[0]}, 32'd0);
    step(5);

    // Bouncing press on B
    key_b = 1'b1; step(1);
    key_b = 1'b0; step(1);
    key_b = 1'b1; step(1);
    key_b = 1'b0; step(1);
    key_b = 1'b1;
    push(cyc + LAT, 4'b0010);
    step(12);
    chk("b_held", {31'd0, held[1]}, 32'd1);
    key_b = 1'b0;
    step(10);

    // Short glitch on F
    key_f = 1'b1;
    step(3);
    key_f = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("f_glitch_held", {31'd0, held[2]}, 32'd0);
      step(1);
    end

    // A held with a short release dip
    key_a = 1'b1;
    push(cyc + LAT, 4'b0001);
    step(15);
    key_a = 1'b0;
    step(2);
    key_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("a_dip_held", {31'd0, held[0]}, 32'd1);
      step(1);
    end
    key_a = 1'b0;
    step(12);
    chk("a_dip_released", {31'd0, held[0]}, 32'd0);

    // Order sequence F, A, F
    key_f = 1'b1;
    push(cyc + LAT, F_EV);
    step(10);
    key_f = 1'b0;
    step(12);
    key_a = 1'b1;
    push(cyc + LAT, 4'b0001);
    step(10);
    key_a = 1'b0;
    step(12);
    key_f = 1'b1;
    push(cyc + LAT, F_EV);
    step(10);
    key_f = 1'b0;
    step(12);

    // A and B qualify in the same cycle
    key_a = 1'b1;
    key_b = 1'b1;
    push(cyc + LAT, 4'b0011);
    step(10);
    key_a = 1'b0;
    key_b = 1'b0;
    step(12);

    // Reset while A is mid-debounce
    key_a = 1'b1;
    step(5);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("reset_mid_held", {29'd0, held}, 32'd0);
    push(cyc + LAT, 4'b0001);
    step(12);
    key_a = 1'b0;
    step(12);

    chk("queue_drained", exp_q.size(), 32'd0);
    if (exp_q.size() != 0)
      $display("FAIL missing_events: %0d expected strobes not seen",
               exp_q.size());

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/key_load_ctrl.md
KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20000, the number of consecutive stable synchronized samples required to accept a press or a release; legal range is 2 to 2^20.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
REQ-004 Port: key_a  input  1  raw, asynchronous, bouncing push-button for the operand-A register load; 1 = pressed.
REQ-005 Port: key_b  input  1  raw push-button for the operand-B register load.
REQ-006 Port: key_f  input  1  raw push-button for the flag-register load.
REQ-007 Port: ld_a  output  1  one-cycle load strobe for the operand-A register.
REQ-008 Port: ld_b  output  1  one-cycle load strobe for the operand-B register.
REQ-009 Port: ld_f  output  1  one-cycle load strobe for the flag register.
REQ-010 Port: held  output  3  debounced pressed level per key, {f,b,a}.
REQ-011 Port: order_err  output  1  one-cycle pulse when a press is suppressed by the order lock.

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each key SHALL have an independent FSM with states IDLE, DB_PRESS, HELD, DB_RELEASE and its own debounce counter.
REQ-014 IDLE -> DB_PRESS when synchronized key = 1; the counter is cleared on entry.
REQ-015 DB_PRESS: the counter increments while the key = 1; key = 0 -> IDLE with no strobe; counter reaching DEBOUNCE_CYCLES-1 with key = 1 -> HELD.
REQ-016 The transition into HELD SHALL raise the key's strobe candidate for exactly one cycle, registered, so the strobe is high in the first cycle the FSM is in HELD.
REQ-017 HELD -> DB_RELEASE when synchronized key = 0; no further strobe while the key is held, regardless of duration.
REQ-018 DB_RELEASE: the counter increments while the key = 0; key = 1 -> HELD with no strobe; counter reaching DEBOUNCE_CYCLES-1 -> IDLE.
REQ-019 The held bit for a key SHALL be 1 in HELD and DB_RELEASE, and 0 otherwise.
REQ-020 Latency: a clean raw rising edge sampled at clk edge N SHALL produce the strobe high during the cycle following edge N+DEBOUNCE_CYCLES+2.
REQ-021 Any pulse on a key shorter than DEBOUNCE_CYCLES cycles after synchronization SHALL produce no strobe.
REQ-022 Counters SHALL saturate and never wrap; counter width is clog2(DEBOUNCE_CYCLES).
REQ-023 Keys qualifying in the same cycle SHALL each produce their strobe in that same cycle; keys do not interact except through REQ-027.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 When rst_n = 0 at a clk edge, the block SHALL set all FSMs to IDLE, counters to 0, synchronizer flops to 0, ld_a/ld_b/ld_f/order_err to 0, held to 3'b000, and the order-lock state to WAIT_A.
REQ-026 A key held through reset deassertion SHALL be treated as a new press and debounced from IDLE; reset mid-DB_PRESS emits no strobe.

Configuration
REQ-027 With macro KEY_ORDER_LOCK_EN defined, a sequencer SHALL follow the states WAIT_A, WAIT_B, WAIT_F with these rules:
- ld_a always passes and moves the sequencer to WAIT_B.
- ld_b passes only in WAIT_B and moves it to WAIT_F.
- ld_f passes only in WAIT_F and moves it to WAIT_A.
- Each candidate is checked against the pre-update state; ld_a wins next-state on collision.
- Any suppressed candidate pulses order_err for one cycle.
REQ-028 Without KEY_ORDER_LOCK_EN, the sequencer SHALL be absent, all candidates SHALL pass, and order_err SHALL be tied to 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Clean press: key_a 0->1 held 20 cycles -> exactly one ld_a pulse, DEBOUNCE_CYCLES+3 cycles after the edge; held[0]=1 until 6 cycles after release.
REQ-030 Bounce: key_b toggles 1,0,1,0 each cycle and then holds 1 -> no strobe during the toggling; a single ld_b after 4 stable samples.
REQ-031 Glitch: key_f high for 3 cycles -> no ld_f, held[2] stays 0.
REQ-032 Release bounce: key_a held, then a 2-cycle low dip, then held again -> no second ld_a, held[0] stays 1.
REQ-033 KEY_ORDER_LOCK_EN defined: press f, then a, then f -> first f suppressed with order_err=1; ld_a passes; second f suppressed with order_err=1, because the sequencer is in WAIT_B.
REQ-034 Reset mid-debounce: rst_n=0 for 1 cycle while key_a is in DB_PRESS count 2 -> no ld_a; with key_a still held, ld_a arrives DEBOUNCE_CYCLES+3 cycles after rst_n returns to 1.
